// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, FSM state encodings and a hex-digit decoder.
package uart_pkg;

    localparam logic [7:0] ChCr   = 8'h0D;
    localparam logic [7:0] ChLf   = 8'h0A;
    localparam logic [7:0] ChDig0 = 8'h30;
    localparam logic [7:0] ChDig9 = 8'h39;
    localparam logic [7:0] ChUpA  = 8'h41;
    localparam logic [7:0] ChUpF  = 8'h46;
    localparam logic [7:0] ChLoA  = 8'h61;
    localparam logic [7:0] ChLoF  = 8'h66;

    localparam logic [1:0] RxIdle  = 2'd0;
    localparam logic [1:0] RxStart = 2'd1;
    localparam logic [1:0] RxData  = 2'd2;
    localparam logic [1:0] RxStop  = 2'd3;

    localparam logic [1:0] PsEmpty   = 2'd0;
    localparam logic [1:0] PsAccum   = 2'd1;
    localparam logic [1:0] PsDiscard = 2'd2;

    typedef struct packed {
        logic       is_hex;
        logic [3:0] nib;
    } hex_dec_t;

    function automatic hex_dec_t hex_decode(input logic [7:0] c);
        hex_dec_t r;
        r.is_hex = 1'b0;
        r.nib    = 4'h0;
        if (c >= ChDig0 && c <= ChDig9) begin
            r.is_hex = 1'b1;
            r.nib    = 4'(c - ChDig0);
        end else if (c >= ChUpA && c <= ChUpF) begin
            r.is_hex = 1'b1;
            r.nib    = 4'(c - ChUpA + 8'd10);
        end else if (c >= ChLoA && c <= ChLoF) begin
            r.is_hex = 1'b1;
            r.nib    = 4'(c - ChLoA + 8'd10);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_hex_parser_if.sv
// Host-facing signal bundle of the UART hex parser: serial input, baud setting and results.
interface uart_hex_parser_if #(
    parameter int unsigned DIGITS = 4
);
    logic [15:0]         baud_div;
    logic                rx_pin;
    logic [4*DIGITS-1:0] hex_val;
    logic                valid;
    logic                err;
    logic                busy;

    modport master (
        output baud_div, rx_pin,
        input  hex_val, valid, err, busy
    );

    modport slave (
        input  baud_div, rx_pin,
        output hex_val, valid, err, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, byte strobe and framing error.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] baud_div_i,
    input  logic        rx_i,
    output logic [7:0]  byte_o,
    output logic        byte_stb_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] tmr_q, tmr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tmr_zero;
    logic        fall;

    assign tmr_zero = (tmr_q == 16'd0);
    assign fall     = rx_prev_q & ~rx_sync_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tmr_d       = tmr_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_stb_o  = 1'b0;
        frame_err_o = 1'b0;
        if (state_q != RxIdle && !tmr_zero) begin
            tmr_d = tmr_q - 16'd1;
        end
        unique case (state_q)
            RxIdle: begin
                if (fall) begin
                    div_d   = baud_div_i;
                    tmr_d   = {1'b0, baud_div_i[15:1]};
                    state_d = RxStart;
                end
            end
            RxStart: begin
                if (tmr_zero) begin
                    if (!rx_sync_q) begin
                        state_d = RxData;
                        bit_d   = 3'd0;
                        tmr_d   = div_q - 16'd1;
                    end else begin
                        state_d = RxIdle;
                    end
                end
            end
            RxData: begin
                if (tmr_zero) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    tmr_d   = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RxStop;
                    end
                end
            end
            RxStop: begin
                // Return to idle at mid stop bit so back-to-back frames are not missed.
                if (tmr_zero) begin
                    state_d = RxIdle;
                    if (rx_sync_q) begin
                        byte_stb_o = 1'b1;
                    end else begin
                        frame_err_o = 1'b1;
                    end
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync chain clears low so a line still low after reset cannot look like a start bit.
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
            state_q   <= RxIdle;
            div_q     <= 16'd0;
            tmr_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            div_q     <= div_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    assign byte_o = shift_q;
    assign busy_o = (state_q != RxIdle);

endmodule

// File: rtl/uart_hex_parser.sv
// UART hex entry: assembles received hex digits into a value, presented on CR or LF.
module uart_hex_parser
    import uart_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input logic               clk,
    input logic               rst,
    uart_hex_parser_if.slave  bus
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(DIGITS + 1);

    logic [7:0]      rx_byte;
    logic            rx_stb;
    logic            rx_ferr;
    logic            rx_busy;
    hex_dec_t        dec;

    logic [1:0]      ps_q, ps_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    hex_q, hex_d;
    logic            valid_q, valid_d;
    logic            err_q;
    logic            perr;

    uart_rx_core u_rx (
        .clk         (clk),
        .rst         (rst),
        .baud_div_i  (bus.baud_div),
        .rx_i        (bus.rx_pin),
        .byte_o      (rx_byte),
        .byte_stb_o  (rx_stb),
        .frame_err_o (rx_ferr),
        .busy_o      (rx_busy)
    );

    assign dec = hex_decode(rx_byte);

    always_comb begin
        ps_d    = ps_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        valid_d = 1'b0;
        perr    = 1'b0;
        if (rx_stb) begin
            if (rx_byte == ChCr || rx_byte == ChLf) begin
                // An empty line (e.g. the LF of CRLF) produces nothing.
                if (ps_q == PsAccum) begin
                    hex_d   = acc_q;
                    valid_d = 1'b1;
                end
                acc_d = '0;
                cnt_d = '0;
                ps_d  = PsEmpty;
            end else if (ps_q != PsDiscard) begin
                if (dec.is_hex && cnt_q < CntW'(DIGITS)) begin
                    acc_d = {acc_q[W-5:0], dec.nib};
                    cnt_d = cnt_q + CntW'(1);
                    ps_d  = PsAccum;
                end else begin
                    perr = 1'b1;
                    ps_d = PsDiscard;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q    <= PsEmpty;
            acc_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            err_q   <= rx_ferr | perr;
        end
    end

    assign bus.hex_val = hex_q;
    assign bus.valid   = valid_q;
    assign bus.err     = err_q;
    assign bus.busy    = rx_busy | (ps_q != PsEmpty);

endmodule

// File: tb/tb_uart_hex_parser.sv
// Scoreboard bench for uart_hex_parser: directed UART strings, expected events queued per string.
module tb_uart_hex_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_hex_parser_if #(.DIGITS(4)) bus ();

    uart_hex_parser #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        is_err;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned div   = 469;

    // Monitor: every valid/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (bus.valid || bus.err)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: valid=%0b err=%0b hex_val=%h, required no event",
                         bus.valid, bus.err, bus.hex_val);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.valid !== ~mon_e.is_err || bus.err !== mon_e.is_err ||
                    bus.hex_val !== mon_e.val) begin
                    n_bad++;
                    $display("FAIL event: valid=%0b err=%0b hex_val=%h, required valid=%0b err=%0b hex_val=%h",
                             bus.valid, bus.err, bus.hex_val, ~mon_e.is_err, mon_e.is_err, mon_e.val);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic is_err, input logic [15:0] val);
        exp_t e;
        e.is_err = is_err;
        e.val    = val;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx_pin = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_pin = b[i];
            repeat (div) @(negedge clk);
        end
        bus.rx_pin = stop_bit;
        repeat (div) @(negedge clk);
        bus.rx_pin = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
        end
    endtask

    task automatic drain(input string name);
        repeat (3 * div) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_pin   = 1'b1;
        bus.baud_div = 16'(div);
        repeat (4) @(negedge clk);
        check("reset_hex_val", 32'(bus.hex_val), 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_err", 32'(bus.err), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Full-rate baud setting for the first value.
        expect_ev(1'b0, 16'h1A2F);
        send_str("1A2f\015");
        drain("drain_1A2f");

        div          = 16;
        bus.baud_div = 16'(div);

        expect_ev(1'b0, 16'h0007);
        send_str("7\015\012");
        drain("drain_7_crlf");

        expect_ev(1'b1, 16'h0007);
        send_str("12345\015");
        drain("drain_overflow");

        expect_ev(1'b1, 16'h0007);
        expect_ev(1'b0, 16'hBEEF);
        send_str("1G3\015");
        send_str("BEEF\012");
        drain("drain_bad_then_beef");

        // Short low glitch must be rejected at the start-bit check.
        bus.rx_pin = 1'b0;
        repeat (div / 4) @(negedge clk);
        bus.rx_pin = 1'b1;
        repeat (div) @(negedge clk);
        check("glitch_busy", 32'(bus.busy), 32'h0);
        drain("drain_glitch");

        expect_ev(1'b1, 16'hBEEF);
        send_byte(8'h31, 1'b0);
        drain("drain_stop_err");

        // Abort a frame mid-DATA with reset, line held low afterwards.
        bus.rx_pin = 1'b0;
        repeat (div) @(negedge clk);
        bus.rx_pin = 1'b1;
        repeat (div) @(negedge clk);
        bus.rx_pin = 1'b0;
        repeat (div / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hex_val", 32'(bus.hex_val), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_err", 32'(bus.err), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("postrst_low_busy", 32'(bus.busy), 32'h0);
        bus.rx_pin = 1'b1;
        repeat (div) @(negedge clk);

        expect_ev(1'b0, 16'h000A);
        send_str("A\015");
        drain("drain_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
